// File: rtl/crc32_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | crc32_pkg: CRC-32 constants, FSM state and mode encodings            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package crc32_pkg;

  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_XOROUT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

  localparam logic MODE_GEN   = 1'b0;
  localparam logic MODE_CHECK = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_FCS  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/crc32_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | crc32_step: DATA_W serial right-shift LFSR iterations, bit 0 first   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module crc32_step #(
  parameter int unsigned DATA_W = 2,
  parameter logic [31:0] POLY   = 32'hEDB88320
) (
  input  logic [31:0]       i_lfsr,
  input  logic [DATA_W-1:0] i_data,
  output logic [31:0]       o_lfsr
);

  for (genvar i = 0; i < DATA_W; i++) begin : g_bit
    logic [31:0] prev_w;
    logic [31:0] nxt_w;
    if (i == 0) begin : g_first
      assign prev_w = i_lfsr;
    end else begin : g_chain
      assign prev_w = g_bit[i-1].nxt_w;
    end
    assign nxt_w = {1'b0, prev_w[31:1]} ^ ((prev_w[0] ^ i_data[i]) ? POLY : 32'h0);
  end

  assign o_lfsr = g_bit[DATA_W-1].nxt_w;

endmodule
`default_nettype wire

// File: rtl/crc32_stream_engine.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | crc32_stream_engine: streaming CRC-32 FCS generator / checker        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module crc32_stream_engine
  import crc32_pkg::*;
#(
  parameter int unsigned DATA_W  = 2,
  parameter logic [31:0] POLY    = CRC32_POLY_REFL,
  parameter logic [31:0] INIT    = CRC32_INIT,
  parameter logic [31:0] XOROUT  = CRC32_XOROUT,
  parameter logic [31:0] RESIDUE = CRC32_RESIDUE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              done,
  output logic              crc_ok,
  output logic [31:0]       crc_value
);

  localparam int unsigned       N_CHUNK   = 32 / DATA_W;
  localparam int unsigned       CNT_W     = $clog2(N_CHUNK) + 1;
  localparam logic [CNT_W-1:0]  C_N_CHUNK = CNT_W'(N_CHUNK);

  state_t            state_q, state_d;
  logic [31:0]       lfsr_q, lfsr_d;
  logic [31:0]       fcs_q, fcs_d;
  logic [31:0]       crc_value_q, crc_value_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mode_q, mode_d;
  logic              started_q, started_d;
  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              m_last_q, m_last_d;
  logic              crc_ok_q, crc_ok_d;

  logic [31:0]       step_w;
  logic [31:0]       fcs_shift_w;
  logic              accept_w;
  logic              cur_mode_w;

  crc32_step #(
    .DATA_W (DATA_W),
    .POLY   (POLY)
  ) u_step (
    .i_lfsr (lfsr_q),
    .i_data (s_data),
    .o_lfsr (step_w)
  );

  // Mode is frozen by the first accepted beat; later changes are ignored.
  assign cur_mode_w  = started_q ? mode_q : mode;
  assign accept_w    = s_valid && s_ready;
  assign fcs_shift_w = fcs_q >> (32'(cnt_q) * DATA_W);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DATA: begin
        if (accept_w && s_last) state_d = (cur_mode_w == MODE_GEN) ? ST_FCS : ST_DONE;
        else                    state_d = ST_DATA;
      end
      ST_FCS:  if (m_valid_q && m_ready && m_last_q) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    s_ready   = !rst && ((state_q == ST_IDLE) || (state_q == ST_DATA)) && (!m_valid_q || m_ready);
    done      = (state_q == ST_DONE);
    m_valid   = m_valid_q;
    m_data    = m_data_q;
    m_last    = m_last_q;
    crc_ok    = crc_ok_q;
    crc_value = crc_value_q;
  end

  always_comb begin
    lfsr_d      = lfsr_q;
    fcs_d       = fcs_q;
    crc_value_d = crc_value_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    started_d   = started_q;
    m_valid_d   = m_valid_q;
    m_data_d    = m_data_q;
    m_last_d    = m_last_q;
    crc_ok_d    = crc_ok_q;

    if (state_q == ST_DONE) begin
      lfsr_d    = INIT;
      started_d = 1'b0;
      cnt_d     = '0;
    end

    if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
    end

    if (accept_w) begin
      lfsr_d = step_w;
      if (!started_q) begin
        mode_d    = mode;
        started_d = 1'b1;
      end
      if (cur_mode_w == MODE_GEN) begin
        m_valid_d = 1'b1;
        m_data_d  = s_data;
        m_last_d  = 1'b0;
      end
      if (s_last) begin
        if (cur_mode_w == MODE_GEN) begin
          fcs_d = step_w ^ XOROUT;
          cnt_d = '0;
        end else begin
          crc_ok_d    = (step_w == RESIDUE);
          crc_value_d = step_w ^ XOROUT;
        end
      end
    end

    // FCS chunks refill the output register whenever it is free or draining.
    if ((state_q == ST_FCS) && (!m_valid_q || m_ready) && (cnt_q < C_N_CHUNK)) begin
      m_valid_d = 1'b1;
      m_data_d  = fcs_shift_w[DATA_W-1:0];
      m_last_d  = (cnt_q == C_N_CHUNK - 1'b1);
      cnt_d     = cnt_q + 1'b1;
    end

    if ((state_q == ST_FCS) && (state_d == ST_DONE)) begin
      crc_value_d = fcs_q;
      crc_ok_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q      <= INIT;
      fcs_q       <= '0;
      crc_value_q <= '0;
      cnt_q       <= '0;
      mode_q      <= MODE_GEN;
      started_q   <= 1'b0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_last_q    <= 1'b0;
      crc_ok_q    <= 1'b0;
    end else begin
      lfsr_q      <= lfsr_d;
      fcs_q       <= fcs_d;
      crc_value_q <= crc_value_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      started_q   <= started_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_last_q    <= m_last_d;
      crc_ok_q    <= crc_ok_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_crc32_stream_engine.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_crc32_stream_engine: directed bench for byte and dibit engines    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_crc32_stream_engine;

  localparam logic GEN = 1'b0;
  localparam logic CHK = 1'b1;

  typedef struct packed {
    logic         sel2;
    logic         mode;
    logic         stall;
    logic         chk_crc;
    logic         exp_ok;
    logic [4:0]   nbytes;
    logic [103:0] data;
    logic [31:0]  exp_crc;
  } vec_t;

  logic clk, rst, mode, s_valid, s_last, m_ready, sel2, stall_en;
  logic [7:0] s_data;

  logic s_valid8, s_valid2, m_ready8, m_ready2;
  logic s_ready8, m_valid8, m_last8, done8, crc_ok8;
  logic s_ready2, m_valid2, m_last2, done2, crc_ok2;
  logic [7:0]  m_data8;
  logic [1:0]  m_data2;
  logic [31:0] crc_value8, crc_value2;

  logic       cur_s_ready, cur_m_valid, cur_m_last, cur_done, cur_crc_ok;
  logic [7:0] cur_m_data;
  logic [31:0] cur_crc_value;

  assign s_valid8 = s_valid & ~sel2;
  assign s_valid2 = s_valid &  sel2;
  assign m_ready8 = m_ready & ~sel2;
  assign m_ready2 = m_ready &  sel2;

  assign cur_s_ready   = sel2 ? s_ready2 : s_ready8;
  assign cur_m_valid   = sel2 ? m_valid2 : m_valid8;
  assign cur_m_last    = sel2 ? m_last2 : m_last8;
  assign cur_m_data    = sel2 ? {6'b0, m_data2} : m_data8;
  assign cur_done      = sel2 ? done2 : done8;
  assign cur_crc_ok    = sel2 ? crc_ok2 : crc_ok8;
  assign cur_crc_value = sel2 ? crc_value2 : crc_value8;

  crc32_stream_engine #(.DATA_W(8)) u_dut8 (
    .clk(clk), .rst(rst), .mode(mode),
    .s_valid(s_valid8), .s_ready(s_ready8), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid8), .m_ready(m_ready8), .m_data(m_data8), .m_last(m_last8),
    .done(done8), .crc_ok(crc_ok8), .crc_value(crc_value8)
  );

  crc32_stream_engine #(.DATA_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .mode(mode),
    .s_valid(s_valid2), .s_ready(s_ready2), .s_data(s_data[1:0]), .s_last(s_last),
    .m_valid(m_valid2), .m_ready(m_ready2), .m_data(m_data2), .m_last(m_last2),
    .done(done2), .crc_ok(crc_ok2), .crc_value(crc_value2)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]  cap[$];
  int          last_cnt, last_pos, done_cnt;
  bit          mv_seen;
  logic        cap_ok;
  logic [31:0] cap_crc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_ready = stall_en ? ~m_ready : 1'b1;
    end
  end

  // Output monitor: capture accepted beats, done results and stall stability.
  initial begin
    bit         prev_stall;
    logic [7:0] prev_data;
    logic       prev_last;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          checks++;
          if (!(cur_m_valid && cur_m_data == prev_data && cur_m_last == prev_last)) begin
            errors++;
            $display("FAIL stall_stable: got v=%0b d=0x%02h l=%0b expected v=1 d=0x%02h l=%0b",
                     cur_m_valid, cur_m_data, cur_m_last, prev_data, prev_last);
          end
        end
        if (cur_m_valid) mv_seen = 1'b1;
        if (cur_m_valid && m_ready) begin
          cap.push_back(cur_m_data);
          if (cur_m_last) begin
            last_cnt++;
            last_pos = cap.size() - 1;
          end
        end
        if (cur_done) begin
          done_cnt++;
          cap_ok  = cur_crc_ok;
          cap_crc = cur_crc_value;
        end
        prev_stall = cur_m_valid && !m_ready;
        prev_data  = cur_m_data;
        prev_last  = cur_m_last;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic put_beat(input logic [7:0] d, input logic last);
    bit ok;
    s_data  = d;
    s_last  = last;
    s_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (cur_s_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout: got s_ready=0 expected s_ready=1 within 200 cycles");
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_frame(input vec_t v);
    int         w;
    logic [7:0] mask, b;
    w    = v.sel2 ? 2 : 8;
    mask = v.sel2 ? 8'h03 : 8'hFF;
    mode = v.mode;
    for (int i = 0; i < int'(v.nbytes); i++) begin
      b = v.data[i*8 +: 8];
      for (int k = 0; k < 8 / w; k++) begin
        if (v.stall) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        put_beat((b >> (k*w)) & mask, (i == int'(v.nbytes) - 1) && (k == 8 / w - 1));
        mode = ~v.mode;
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    logic [7:0] exp_q[$];
    int         w, bad, first_bad;
    logic [7:0] mask, b;
    cap.delete();
    done_cnt = 0;
    last_cnt = 0;
    last_pos = -1;
    mv_seen  = 1'b0;
    sel2     = v.sel2;
    stall_en = v.stall;
    @(posedge clk);
    #1;
    w    = v.sel2 ? 2 : 8;
    mask = v.sel2 ? 8'h03 : 8'hFF;
    if (v.mode == GEN) begin
      for (int i = 0; i < int'(v.nbytes); i++) begin
        b = v.data[i*8 +: 8];
        for (int k = 0; k < 8 / w; k++) exp_q.push_back((b >> (k*w)) & mask);
      end
      for (int j = 0; j < 32 / w; j++) exp_q.push_back(8'(v.exp_crc >> (j*w)) & mask);
    end
    send_frame(v);
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (done_cnt != 0) break;
    end
    repeat (4) @(negedge clk);
    stall_en = 1'b0;

    chk({nm, " beat_count"}, cap.size(), exp_q.size());
    bad = 0;
    first_bad = -1;
    for (int i = 0; i < cap.size() && i < exp_q.size(); i++) begin
      if (cap[i] !== exp_q[i]) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
    end
    if (first_bad >= 0)
      $display("  %s first differing beat %0d: got 0x%02h expected 0x%02h",
               nm, first_bad, cap[first_bad], exp_q[first_bad]);
    chk({nm, " beat_data_diffs"}, bad, 0);
    chk({nm, " done_pulses"}, done_cnt, 1);
    if (v.mode == GEN) begin
      chk({nm, " m_last_count"}, last_cnt, 1);
      chk({nm, " m_last_pos"}, last_pos, exp_q.size() - 1);
    end else begin
      chk({nm, " m_valid_seen"}, mv_seen, 0);
      chk({nm, " crc_ok"}, cap_ok, v.exp_ok);
    end
    if (v.chk_crc) chk({nm, " crc_value"}, cap_crc, v.exp_crc);
  endtask

  vec_t  vecs[8];
  string names[8];

  initial begin
    rst = 1'b1;
    mode = GEN;
    s_valid = 1'b0;
    s_last = 1'b0;
    s_data = '0;
    sel2 = 1'b0;
    stall_en = 1'b0;
    cap_ok = 1'b0;
    cap_crc = '0;

    vecs[0] = '{sel2:1'b0, mode:GEN, stall:1'b0, chk_crc:1'b1, exp_ok:1'b0, nbytes:5'd9,
                data:104'h393837363534333231, exp_crc:32'hCBF43926};
    names[0] = "gen8_123456789";
    vecs[1] = '{sel2:1'b1, mode:GEN, stall:1'b0, chk_crc:1'b1, exp_ok:1'b0, nbytes:5'd9,
                data:104'h393837363534333231, exp_crc:32'hCBF43926};
    names[1] = "gen2_123456789";
    vecs[2] = '{sel2:1'b1, mode:CHK, stall:1'b0, chk_crc:1'b1, exp_ok:1'b1, nbytes:5'd13,
                data:104'hCBF43926393837363534333231, exp_crc:32'h2144DF1C};
    names[2] = "chk2_good";
    vecs[3] = '{sel2:1'b1, mode:CHK, stall:1'b0, chk_crc:1'b0, exp_ok:1'b0, nbytes:5'd13,
                data:104'hCBF43926393837363534333230, exp_crc:32'h0};
    names[3] = "chk2_bitflip";
    vecs[4] = '{sel2:1'b0, mode:GEN, stall:1'b1, chk_crc:1'b1, exp_ok:1'b0, nbytes:5'd9,
                data:104'h393837363534333231, exp_crc:32'hCBF43926};
    names[4] = "gen8_stalled";
    vecs[5] = '{sel2:1'b0, mode:GEN, stall:1'b0, chk_crc:1'b1, exp_ok:1'b0, nbytes:5'd1,
                data:104'h00, exp_crc:32'hD202EF8D};
    names[5] = "gen8_one_zero_byte";
    vecs[6] = '{sel2:1'b0, mode:CHK, stall:1'b0, chk_crc:1'b1, exp_ok:1'b1, nbytes:5'd13,
                data:104'hCBF43926393837363534333231, exp_crc:32'h2144DF1C};
    names[6] = "chk8_good";
    vecs[7] = '{sel2:1'b0, mode:CHK, stall:1'b0, chk_crc:1'b1, exp_ok:1'b0, nbytes:5'd1,
                data:104'h00, exp_crc:32'hD202EF8D};
    names[7] = "chk8_short_frame";

    #3;
    chk("reset_outputs_dut8",
        {s_ready8, m_valid8, m_data8, m_last8, done8, crc_ok8, crc_value8}, 64'h0);
    chk("reset_outputs_dut2",
        {s_ready2, m_valid2, m_data2, m_last2, done2, crc_ok2, crc_value2}, 64'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], names[i]);

    // Abort a GEN frame with reset while its FCS is being emitted.
    sel2 = 1'b0;
    stall_en = 1'b0;
    cap.delete();
    done_cnt = 0;
    @(posedge clk);
    #1;
    mode = GEN;
    for (int i = 0; i < 9; i++) put_beat(8'h31 + 8'(i), i == 8);
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (cap.size() >= 11) break;
    end
    chk("abort_reached_fcs", cap.size() >= 11, 1);
    rst = 1'b1;
    #1;
    chk("abort_reset_outputs",
        {s_ready8, m_valid8, m_data8, m_last8, done8, crc_ok8, crc_value8}, 64'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_no_done", done_cnt, 0);
    run_vec(vecs[0], "gen8_after_abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
